// File: rtl/alu_ctrl_seq_pkg.sv
// alu_ctrl_pkg: shared encodings for the ID/EX ALU controller.
//   - ALUOp class constants (main-decoder output)
//   - R-type funct field constants
//   - 4-bit ALU control codes
//   - FSM state type and the is_multicycle helper
package alu_ctrl_pkg;

    // ALUOp classes
    localparam logic [2:0] OP_RTYPE  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_ADDI   = 3'b010;
    localparam logic [2:0] OP_SLTI   = 3'b011;
    localparam logic [2:0] OP_ANDI   = 3'b100;
    localparam logic [2:0] OP_ORI    = 3'b101;
    localparam logic [2:0] OP_LUI    = 3'b110;
    localparam logic [2:0] OP_ILL    = 3'b111;

    // R-type funct values
    localparam logic [5:0] F_SLL  = 6'd0;
    localparam logic [5:0] F_SRL  = 6'd2;
    localparam logic [5:0] F_SRA  = 6'd3;
    localparam logic [5:0] F_JR   = 6'd8;
    localparam logic [5:0] F_MULT = 6'd24;
    localparam logic [5:0] F_DIV  = 6'd26;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_NOR  = 6'd39;
    localparam logic [5:0] F_SLT  = 6'd42;
    localparam logic [5:0] F_SLTU = 6'd43;

    // ALU control codes
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SLL  = 4'b0011;
    localparam logic [3:0] C_SRL  = 4'b0100;
    localparam logic [3:0] C_SRA  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MULT = 4'b1001;
    localparam logic [3:0] C_DIV  = 4'b1010;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_LUI  = 4'b1101;
    localparam logic [3:0] C_SLTU = 4'b1111;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    // Only mult/div occupy the EX unit for more than one cycle.
    function automatic logic is_multicycle(input logic [3:0] ctrl);
        return (ctrl == C_MULT) || (ctrl == C_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: decode-side request and EX-side control bundle.
//   master: the decode stage / driver (drives *_i, reads *_o)
//   slave : alu_ctrl_seq (reads *_i, drives *_o)
interface alu_ctrl_seq_if #(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4
);
    logic               valid_i;
    logic               ready_o;
    logic [FUNCT_W-1:0] funct_i;
    logic [ALUOP_W-1:0] ALUOp_i;
    logic [4:0]         shamt_i;
    logic               stall_i;
    logic               flush_i;
    logic               valid_o;
    logic [CTRL_W-1:0]  ALUCtrl_o;
    logic [4:0]         shamt_o;
    logic               jr_o;
    logic               illegal_o;
    logic               busy_o;

    modport master (
        output valid_i, funct_i, ALUOp_i, shamt_i, stall_i, flush_i,
        input  ready_o, valid_o, ALUCtrl_o, shamt_o, jr_o, illegal_o, busy_o
    );

    modport slave (
        input  valid_i, funct_i, ALUOp_i, shamt_i, stall_i, flush_i,
        output ready_o, valid_o, ALUCtrl_o, shamt_o, jr_o, illegal_o, busy_o
    );
endinterface

// File: rtl/alu_ctrl_seq_dec.sv
// alu_ctrl_dec: purely combinational ALU control decode.
//   in : ALUOp_i, funct_i
//   out: ctrl (ALU control code), jr, illegal, multi (multi-cycle op),
//        lat (initial busy-counter value, i.e. latency-1, for multi ops)
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 3
) (
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               jr,
    output logic               illegal,
    output logic               multi,
    output logic [CNT_W-1:0]   lat
);
    logic [3:0] code;

    always_comb begin
        code    = C_AND;
        jr      = 1'b0;
        illegal = 1'b0;
        case (ALUOp_i)
            ALUOP_W'(OP_RTYPE): begin
                case (funct_i)
                    FUNCT_W'(F_ADD):  code = C_ADD;
                    FUNCT_W'(F_SUB):  code = C_SUB;
                    FUNCT_W'(F_AND):  code = C_AND;
                    FUNCT_W'(F_OR):   code = C_OR;
                    FUNCT_W'(F_NOR):  code = C_NOR;
                    FUNCT_W'(F_SLT):  code = C_SLT;
                    FUNCT_W'(F_SLTU): code = C_SLTU;
                    FUNCT_W'(F_SLL):  code = C_SLL;
                    FUNCT_W'(F_SRL):  code = C_SRL;
                    FUNCT_W'(F_SRA):  code = C_SRA;
                    FUNCT_W'(F_JR): begin
                        code = C_ADD;
                        jr   = 1'b1;
                    end
                    FUNCT_W'(F_MULT): code = C_MULT;
                    FUNCT_W'(F_DIV):  code = C_DIV;
                    default:          illegal = 1'b1;
                endcase
            end
            ALUOP_W'(OP_BRANCH): code = C_SUB;
            ALUOP_W'(OP_ADDI):   code = C_ADD;
            ALUOP_W'(OP_SLTI):   code = C_SLT;
            ALUOP_W'(OP_ANDI):   code = C_AND;
            ALUOP_W'(OP_ORI):    code = C_OR;
            ALUOP_W'(OP_LUI):    code = C_LUI;
            default:             illegal = 1'b1;  // OP_ILL and any wider encodings
        endcase
    end

    assign ctrl  = CTRL_W'(code);
    assign multi = is_multicycle(code);
    // Counter preload is latency-1: the final BUSY cycle is the one with cnt==0.
    assign lat   = (code == C_DIV) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU controller at the ID/EX boundary.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : alu_ctrl_seq_if.slave -- decode request (valid/funct/ALUOp/shamt),
//           stall/flush, registered control outputs, ready/busy status.
// mult/div hold the block in BUSY for MUL_LAT/DIV_LAT cycles after the accept,
// back-pressuring decode through ready_o.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_ctrl_seq_if.slave  bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CTRL_W-1:0]  dec_ctrl;
    logic               dec_jr, dec_ill, dec_multi;
    logic [CNT_W-1:0]   dec_lat;
    logic               accept;

    alu_ctrl_dec #(
        .FUNCT_W (FUNCT_W),
        .ALUOP_W (ALUOP_W),
        .CTRL_W  (CTRL_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_dec (
        .ALUOp_i (bus.ALUOp_i),
        .funct_i (bus.funct_i),
        .ctrl    (dec_ctrl),
        .jr      (dec_jr),
        .illegal (dec_ill),
        .multi   (dec_multi),
        .lat     (dec_lat)
    );

    // Flush and stall both block acceptance, so anything presented with
    // flush_i is dropped rather than queued.
    assign bus.ready_o = (state_q == ST_IDLE) && !bus.stall_i && !bus.flush_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign bus.busy_o  = (state_q == ST_BUSY);

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. The counter keeps running under stall; only flush stops it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept && dec_multi) begin
            state_d = ST_BUSY;
            cnt_d   = dec_lat;
        end else if (state_q == ST_BUSY) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Output registers. Flush clears the qualifiers but leaves the
    // ctrl/shamt payload in place; it is meaningless while valid_o=0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.valid_o   <= 1'b0;
            bus.ALUCtrl_o <= '0;
            bus.shamt_o   <= '0;
            bus.jr_o      <= 1'b0;
            bus.illegal_o <= 1'b0;
        end else if (bus.flush_i) begin
            bus.valid_o   <= 1'b0;
            bus.jr_o      <= 1'b0;
            bus.illegal_o <= 1'b0;
        end else if (accept) begin
            bus.valid_o   <= 1'b1;
            bus.ALUCtrl_o <= dec_ctrl;
            bus.shamt_o   <= bus.shamt_i;
            bus.jr_o      <= dec_jr;
            bus.illegal_o <= dec_ill;
        end else if (!bus.stall_i) begin
            bus.valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       jr;
        logic       ill;
        logic [4:0] sh;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    alu_ctrl_seq_if #(.FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4)) bus ();

    alu_ctrl_seq #(
        .FUNCT_W (6),
        .ALUOP_W (3),
        .CTRL_W  (4),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    // Reference decode table, written from the instruction encoding list.
    function automatic exp_t model(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh);
        exp_t e;
        e = '{ctrl: 4'b0000, jr: 1'b0, ill: 1'b0, sh: sh};
        case (op)
            3'b000: case (fn)
                6'd32: e.ctrl = 4'b0010;
                6'd34: e.ctrl = 4'b0110;
                6'd36: e.ctrl = 4'b0000;
                6'd37: e.ctrl = 4'b0001;
                6'd39: e.ctrl = 4'b1100;
                6'd42: e.ctrl = 4'b0111;
                6'd43: e.ctrl = 4'b1111;
                6'd0:  e.ctrl = 4'b0011;
                6'd2:  e.ctrl = 4'b0100;
                6'd3:  e.ctrl = 4'b0101;
                6'd8:  begin e.ctrl = 4'b0010; e.jr = 1'b1; end
                6'd24: e.ctrl = 4'b1001;
                6'd26: e.ctrl = 4'b1010;
                default: e.ill = 1'b1;
            endcase
            3'b001: e.ctrl = 4'b0110;
            3'b010: e.ctrl = 4'b0010;
            3'b011: e.ctrl = 4'b0111;
            3'b100: e.ctrl = 4'b0000;
            3'b101: e.ctrl = 4'b0001;
            3'b110: e.ctrl = 4'b1101;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present an instruction that should be accepted at the next edge.
    task automatic send(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh);
        bus.valid_i = 1'b1;
        bus.ALUOp_i = op;
        bus.funct_i = fn;
        bus.shamt_i = sh;
        #0;
        check("ready_on_send", bus.ready_o, 1'b1);
        sb.push_back(model(op, fn, sh));
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, bus.valid_o, 1'b1);
        check({tag, "_ctrl"},  bus.ALUCtrl_o, e.ctrl);
        check({tag, "_jr"},    bus.jr_o, e.jr);
        check({tag, "_ill"},   bus.illegal_o, e.ill);
        check({tag, "_shamt"}, bus.shamt_o, e.sh);
    endtask

    task automatic idle_inputs();
        bus.valid_i = 1'b0;
        bus.ALUOp_i = 3'b000;
        bus.funct_i = 6'd0;
        bus.shamt_i = 5'd0;
    endtask

    // Multi-cycle op: busy/back-pressure for lat cycles, a pending add is held off.
    task automatic run_multi(input string tag, input logic [5:0] fn, input int lat);
        send(3'b000, fn, 5'd7);
        tick();
        expect_out(tag);
        bus.valid_i = 1'b1;
        bus.funct_i = 6'd32;
        bus.shamt_i = 5'd1;
        for (int c = 1; c <= lat; c++) begin
            #0;
            check({tag, "_busy"},  bus.busy_o, 1'b1);
            check({tag, "_ready"}, bus.ready_o, 1'b0);
            if (c >= 2) check({tag, "_hold_valid"}, bus.valid_o, 1'b0);
            tick();
        end
        check({tag, "_busy_end"}, bus.busy_o, 1'b0);
        send(3'b000, 6'd32, 5'd1);
        tick();
        expect_out({tag, "_next"});
        idle_inputs();
    endtask

    initial begin
        logic [5:0] rfn [10];
        logic [2:0] iop [6];
        rfn = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd43, 6'd0, 6'd2, 6'd3};
        iop = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        idle_inputs();
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_ctrl",  bus.ALUCtrl_o, 4'b0000);
        check("rst_shamt", bus.shamt_o, 5'd0);
        check("rst_jr",    bus.jr_o, 1'b0);
        check("rst_ill",   bus.illegal_o, 1'b0);
        check("rst_busy",  bus.busy_o, 1'b0);
        rst_i = 1'b1;
        #1;
        check("rst_ready", bus.ready_o, 1'b1);
        tick();

        // R-type sweep, back-to-back
        send(3'b000, rfn[0], 5'd1);
        for (int i = 1; i < 10; i++) begin
            tick();
            expect_out("rsweep");
            send(3'b000, rfn[i], 5'(i * 3 + 1));
        end
        tick();
        expect_out("rsweep");
        idle_inputs();
        tick();
        check("rsweep_drop_valid", bus.valid_o, 1'b0);

        // I-type classes; funct deliberately set to garbage
        for (int i = 0; i < 6; i++) begin
            send(iop[i], 6'd63, 5'(i + 20));
            tick();
            expect_out("itype");
        end
        idle_inputs();

        // Illegal / jr encodings
        send(3'b111, 6'd32, 5'd2);  tick(); expect_out("ill_op7");
        send(3'b000, 6'd8,  5'd3);  tick(); expect_out("jr");
        send(3'b000, 6'd63, 5'd4);  tick(); expect_out("ill_f63");
        idle_inputs();
        tick();

        // Multi-cycle ops
        run_multi("mult", 6'd24, MUL_LAT);
        tick();
        run_multi("div", 6'd26, DIV_LAT);
        tick();

        // Stall after addi: output held, new request not taken
        send(3'b010, 6'd0, 5'd9);
        tick();
        expect_out("addi");
        bus.stall_i = 1'b1;
        bus.ALUOp_i = 3'b101;
        bus.shamt_i = 5'd10;
        #0;
        check("stall_ready", bus.ready_o, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_valid", bus.valid_o, 1'b1);
            check("stall_ctrl",  bus.ALUCtrl_o, 4'b0010);
            check("stall_shamt", bus.shamt_o, 5'd9);
        end
        bus.stall_i = 1'b0;
        send(3'b101, 6'd0, 5'd10);
        tick();
        expect_out("after_stall");
        idle_inputs();
        tick();

        // Flush during div BUSY
        send(3'b000, 6'd26, 5'd5);
        tick();
        expect_out("fdiv");
        idle_inputs();
        tick();
        check("fdiv_busy_c2", bus.busy_o, 1'b1);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.funct_i = 6'd32;
        #0;
        check("fdiv_ready_flush", bus.ready_o, 1'b0);
        tick();
        bus.flush_i = 1'b0;
        idle_inputs();
        #0;
        check("fdiv_busy_c3",  bus.busy_o, 1'b0);
        check("fdiv_valid_c3", bus.valid_o, 1'b0);
        check("fdiv_ready_c3", bus.ready_o, 1'b1);
        check("fdiv_ctrl_hold", bus.ALUCtrl_o, 4'b1010);
        tick();

        // Flush right after jr clears valid/jr, keeps ctrl
        send(3'b000, 6'd8, 5'd6);
        tick();
        expect_out("fjr");
        idle_inputs();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("fjr_valid", bus.valid_o, 1'b0);
        check("fjr_jr",    bus.jr_o, 1'b0);
        check("fjr_ctrl",  bus.ALUCtrl_o, 4'b0010);
        check("fjr_shamt", bus.shamt_o, 5'd6);
        tick();

        // Reset mid-BUSY
        send(3'b000, 6'd24, 5'd11);
        tick();
        expect_out("rmult");
        idle_inputs();
        #2;
        rst_i = 1'b0;
        #1;
        check("rmid_valid", bus.valid_o, 1'b0);
        check("rmid_busy",  bus.busy_o, 1'b0);
        check("rmid_ctrl",  bus.ALUCtrl_o, 4'b0000);
        check("rmid_shamt", bus.shamt_o, 5'd0);
        rst_i = 1'b1;
        #1;
        check("rmid_ready", bus.ready_o, 1'b1);
        tick();
        check("rmid_busy_after", bus.busy_o, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Registered, handshaked ALU controller for the pipelined CPU, sitting at the ID/EX boundary. Decodes ALUOp_i/funct_i into the 4-bit ALU control code for an extended instruction set (shifts, nor, lui, slti/andi/ori, jr, mult/div). Sequences multi-cycle mult/div with a latency counter, back-pressuring decode via ready_o. Honours downstream stall and pipeline flush.

Parameters:
FUNCT_W, 6, funct field width
ALUOP_W, 3, ALUOp width
CTRL_W, 4, ALU control code width
MUL_LAT, 4, busy cycles for mult (>=1)
DIV_LAT, 8, busy cycles for div (>=1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
valid_i  input  1  decode presents an instruction
ready_o  output  1  block can accept; combinational = state==IDLE && !stall_i && !flush_i
funct_i  input  FUNCT_W  instruction funct field
ALUOp_i  input  ALUOP_W  main-decoder ALU class
shamt_i  input  5  shift amount field
stall_i  input  1  EX stage cannot take new control
flush_i  input  1  synchronous pipeline flush
valid_o  output  1  registered control valid
ALUCtrl_o  output  CTRL_W  registered ALU control code
shamt_o  output  5  registered shift amount
jr_o  output  1  registered jr indicator
illegal_o  output  1  registered undefined-encoding flag
busy_o  output  1  multi-cycle unit occupied

Behaviour:
- Reset (rst_i=0, async): all outputs 0, ALUCtrl_o=0000, state IDLE, counter 0.
- Accept = valid_i && ready_o. On accept: outputs registered next edge (latency 1), valid_o<=1.
- No accept: if !stall_i then valid_o<=0, other outputs hold; if stall_i all outputs hold.
- Decode, ALUOp 000 (R-type) by funct: 32 add->0010; 34 sub->0110; 36 and->0000; 37 or->0001; 39 nor->1100; 42 slt->0111; 43 sltu->1111; 0 sll->0011; 2 srl->0100; 3 sra->0101; 8 jr->0010 with jr_o=1; 24 mult->1001 (multi-cycle); 26 div->1010 (multi-cycle); other funct->0000 with illegal_o=1.
- ALUOp 001 branch->0110; 010 addi->0010; 011 slti->0111; 100 andi->0000; 101 ori->0001; 110 lui->1101; 111->0000, illegal_o=1. funct ignored for non-R-type.
- jr_o/illegal_o are 0 for every encoding not listed above; shamt_o = shamt_i on every accept.
- FSM IDLE/BUSY. Accept of mult: cnt<=MUL_LAT-1, ->BUSY; div: cnt<=DIV_LAT-1, ->BUSY. BUSY: cnt decrements each cycle; BUSY with cnt==0 ->IDLE next edge. busy_o = (state==BUSY); mult therefore holds busy_o for exactly MUL_LAT cycles after the accept cycle.
- Counter is not frozen by stall_i. If BUSY ends while stall_i=1, ready_o stays 0 until stall_i drops.
- flush_i (sync, highest priority over accept/stall/BUSY): valid_o<=0, jr_o<=0, illegal_o<=0, state<=IDLE, cnt<=0, busy_o 0 next cycle; ALUCtrl_o/shamt_o hold. An input coincident with flush_i is dropped (ready_o=0).
- Reset mid-BUSY: immediate return to reset values.
- Illegal encodings are accepted normally (single-cycle), never X.

Decomposition:
- Package alu_ctrl_pkg: ALUOp class constants, funct constants, ALU control code constants, the is_multicycle helper.
- Sub-module alu_ctrl_dec: pure combinational decode (ALUOp, funct -> ctrl, jr, illegal, multi, lat); alu_ctrl_seq holds the handshake, output registers, FSM and counter.

Test Plan:
- Reset: rst_i low mid-operation -> all outputs 0, ready_o=1 after release with stall_i=0.
- R-type sweep: ALUOp=000, funct 32/34/36/37/39/42/43/0/2/3 back-to-back -> ALUCtrl_o 0010/0110/0000/0001/1100/0111/1111/0011/0100/0101 one cycle later, valid_o held 1.
- mult: accept funct 24 at cycle 0 -> ALUCtrl_o=1001 cycle 1, busy_o=1 cycles 1-4, ready_o=0 cycles 1-4, ready_o=1 cycle 5; div same with busy cycles 1-8.
- Stall: stall_i=1 for 3 cycles after addi accept -> ALUCtrl_o=0010, valid_o=1 held; new valid_i not accepted until stall_i=0.
- Flush during BUSY: flush at cycle 2 of div -> cycle 3 busy_o=0, valid_o=0, ready_o=1.
- Illegal/jr: ALUOp=111 -> illegal_o=1, ALUCtrl_o=0000; funct 8 -> jr_o=1, ALUCtrl_o=0010; funct 63 -> illegal_o=1.
